ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Upstream controller that turns the 32x32 single-port RAM into a show-ahead FIFO.
//  Drives the RAM's ena/wena/addr/data_in pins and captures its data_out into an output register.
//  The RAM allows one access per cycle, so the block arbitrates between writes (push) and
//  output-register refills (read), alternating fairly when both compete.
// PARAMETERS
//  DW     32  data width; must match the RAM word width
//  AW      5  RAM address width
//  DEPTH  32  RAM entries; must equal 2**AW
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      synchronous reset, active low
//  push        in   1      producer offers push_data
//  push_data   in   DW     word to enqueue
//  push_ready  out  1      push accepted on an edge where push & push_ready
//  pop         in   1      consumer takes pop_data; ignored when pop_valid=0
//  pop_data    out  DW     head of FIFO (registered)
//  pop_valid   out  1      pop_data holds a valid word
//  full        out  1      ram_cnt==DEPTH
//  empty       out  1      ~pop_valid
//  count       out  AW+1   ram_cnt + pop_valid, range 0..DEPTH+1 (6 bits covers 0..33)
//  ram_ena     out  1      RAM enable
//  ram_wena    out  1      RAM write enable
//  ram_addr    out  AW     RAM address
//  ram_wdata   out  DW     RAM write data (= push_data)
//  ram_rdata   in   DW     RAM read data; combinational, Z when not reading
// BEHAVIOUR
//  State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], ram_cnt[AW:0], pop_data, pop_valid, prio (0=read wins).
//  Reset (rst_n=0 at an edge): all state cleared to 0. While rst_n=0: ram_ena=0, push_ready=0.
//   RAM contents are not cleared; they become don't-care.
//  rd_want = (ram_cnt!=0) & (~pop_valid | pop).   wr_ok = (ram_cnt!=DEPTH).
//  push_ready = wr_ok & ~(rd_want & ~prio). It depends combinationally on pop, not on push.
//  rd_go = rd_want & ~(prio & push & wr_ok).   wr_go = push & push_ready.
//   Exactly one of rd_go/wr_go, or neither, per cycle.
//  prio toggles only on a contested cycle (rd_want & push & wr_ok); otherwise it holds.
//  Read cycle: ram_ena=1, ram_wena=0, ram_addr=rd_ptr.
//   Edge: pop_data<=ram_rdata, pop_valid<=1, rd_ptr++, ram_cnt--.
//  Write cycle: ram_ena=1, ram_wena=1, ram_addr=wr_ptr.
//   Edge: RAM stores push_data, wr_ptr++, ram_cnt++.
//  Idle cycle: ram_ena=0, ram_wena=0, ram_addr=rd_ptr. ram_rdata is never sampled while idle.
//  Pop with pop_valid=1 and no rd_go: pop_valid<=0 at the edge; pop_data holds its old value.
//  Pop together with rd_go: pop_data is replaced and pop_valid stays 1 (one word/cycle throughput).
//  Pointers wrap DEPTH-1 -> 0 by natural AW-bit overflow.
//  Overflow protection: push while full is not accepted. Underflow: pop while ~pop_valid is a no-op.
//  Latency: a word pushed into an empty FIFO at edge N appears with pop_valid=1 after edge N+1.
//   Without contention it is read at N+1. There is no bypass path.
//  Capacity: DEPTH+1 words (DEPTH in RAM plus 1 in the output register).
//  Ordering: strict FIFO order is kept under every arbitration outcome.
// TESTING
//  1 Reset: rst_n=0 for 2 edges with push=1.
//    -> count=0, empty=1, full=0, pop_valid=0, ram_ena=0, nothing written.
//  2 Single word: push 0xA5A50001 for one cycle, pop=0.
//    -> write to addr 0, then read of addr 0 next cycle.
//    -> pop_valid=1 with pop_data=0xA5A50001 after the 2nd edge; count=1.
//  3 Fill: push 1..34 back-to-back, pop=0.
//    -> word 1 in output register; full=1 and count=33 after the 33rd accept.
//    -> push_ready=0 from then on; word 34 is not accepted.
//  4 Contention: hold push=1 and pop=1 with a non-empty FIFO.
//    -> read and write grants alternate every cycle; prio toggles each contested cycle.
//    -> no data loss.
//  5 Streaming wrap: push words 0..99 with random push/pop gaps.
//    -> popped sequence is exactly 0..99; pointers wrap 31->0 at least 3 times.
//  6 Reset mid-operation: count=10, then rst_n=0 for 1 edge, then push 0x00001234.
//    -> count=1, and the first popped word is 0x00001234 (no stale data).

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller in front of a single-port RAM. One RAM access per cycle;
// refill reads of the output register and pushes share the port with fair alternation.
module ram_fifo_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          prio;
  logic          rd_want, wr_ok, contested, rd_go, wr_go;

  always_comb begin
    rd_want   = (ram_cnt != '0) && (!pop_valid || pop);
    wr_ok     = (ram_cnt != FULL_CNT);
    contested = rd_want && push && wr_ok;
    // prio=0 lets the refill read win a contested cycle; prio=1 lets the push win.
    push_ready = rst_n && wr_ok && !(rd_want && !prio);
    rd_go      = rst_n && rd_want && !(prio && push && wr_ok);
    wr_go      = push && push_ready;
  end

  assign ram_ena   = rd_go || wr_go;
  assign ram_wena  = wr_go;
  assign ram_addr  = wr_go ? wr_ptr : rd_ptr;
  assign ram_wdata = push_data;
  assign full      = (ram_cnt == FULL_CNT);
  assign empty     = !pop_valid;
  assign count     = ram_cnt + {{AW{1'b0}}, pop_valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      prio      <= 1'b0;
    end else begin
      if (wr_go) begin
        wr_ptr  <= wr_ptr + AW'(1);
        ram_cnt <= ram_cnt + (AW+1)'(1);
      end else if (rd_go) begin
        rd_ptr  <= rd_ptr + AW'(1);
        ram_cnt <= ram_cnt - (AW+1)'(1);
      end
      // A refill replaces the head even while it is being popped, keeping one word/cycle.
      if (rd_go) begin
        pop_data  <= ram_rdata;
        pop_valid <= 1'b1;
      end else if (pop && pop_valid) begin
        pop_valid <= 1'b0;
      end
      if (contested) prio <= !prio;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised and directed bench for ram_fifo_ctrl with a 32x32 RAM model and a queue-based
// FIFO model advanced once per cycle on the falling edge.
module tb_ram_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, pop;
  logic [31:0] push_data;
  logic        push_ready, pop_valid, full, empty;
  logic [31:0] pop_data;
  logic [5:0]  count;
  logic        ram_ena, ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(32), .AW(5), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .count(count), .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM: synchronous write, combinational read, Z when not reading.
  logic [31:0] mem [32];
  int          wr_strobes = 0;
  always @(posedge clk) begin
    if (ram_ena && ram_wena) begin
      mem[ram_addr] <= ram_wdata;
      wr_strobes    <= wr_strobes + 1;
    end
  end
  assign ram_rdata = (ram_ena && !ram_wena) ? mem[ram_addr] : 'z;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: words held in RAM as a queue, plus the output register and arbitration bit.
  logic [31:0] ram_q [$];
  logic [31:0] popped [$];
  logic        m_ov, m_prio;
  logic [31:0] m_od;
  int          m_wr, m_rd;
  int          wraps, last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic model_step();
    int  rc;
    bit  rd_want, wr_ok, pr, rd_go, wr_go;
    if (!rst_n) begin
      chk("rst_push_ready", push_ready, 0);
      chk("rst_ram_ena", ram_ena, 0);
      ram_q.delete(); popped.delete();
      m_ov = 0; m_od = 0; m_prio = 0; m_wr = 0; m_rd = 0; wraps = 0; last_rd = -1;
      return;
    end
    rc = ram_q.size();
    chk("pop_valid", pop_valid, m_ov);
    if (m_ov) chk("pop_data", pop_data, m_od);
    chk("count", count, rc + int'(m_ov));
    chk("full", full, rc == 32);
    chk("empty", empty, !m_ov);
    rd_want = rc != 0 && (!m_ov || pop);
    wr_ok   = rc != 32;
    pr      = wr_ok && !(rd_want && !m_prio);
    rd_go   = rd_want && !(m_prio && push && wr_ok);
    wr_go   = push && pr;
    chk("push_ready", push_ready, pr);
    chk("ram_ena", ram_ena, rd_go || wr_go);
    chk("ram_wena", ram_wena, wr_go);
    chk("ram_addr", ram_addr, (wr_go ? m_wr : m_rd) % 32);
    if (wr_go) chk("ram_wdata", ram_wdata, push_data);
    if (ram_ena && !ram_wena) begin
      if (last_rd == 31 && ram_addr == 0) wraps++;
      last_rd = ram_addr;
    end
    if (pop && m_ov) popped.push_back(m_od);
    if (wr_go) begin ram_q.push_back(push_data); m_wr++; end
    if (rd_go) begin m_od = ram_q.pop_front(); m_ov = 1; m_rd++; end
    else if (pop && m_ov) m_ov = 0;
    if (rd_want && push && wr_ok) m_prio = !m_prio;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  k, guard;
    bit  acc, prev;
    rst_n = 0; push = 1; push_data = 32'hFFFF0000; pop = 0;
    // Reset held for two edges with push asserted
    tick();
    chk("t1_ram_ena", ram_ena, 0);
    chk("t1_push_ready", push_ready, 0);
    tick();
    rst_n = 1; push = 0; #1;
    chk("t1_count", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_full", full, 0);
    chk("t1_pop_valid", pop_valid, 0);
    chk("t1_ram_ena_idle", ram_ena, 0);
    chk("t1_no_writes", wr_strobes, 0);

    // Single word: write addr 0, then read addr 0
    push = 1; push_data = 32'hA5A50001; #1;
    chk("t2_wr_ena", ram_ena, 1);
    chk("t2_wr_wena", ram_wena, 1);
    chk("t2_wr_addr", ram_addr, 0);
    tick();
    push = 0; #1;
    chk("t2_rd_ena", ram_ena, 1);
    chk("t2_rd_wena", ram_wena, 0);
    chk("t2_rd_addr", ram_addr, 0);
    tick();
    chk("t2_pop_valid", pop_valid, 1);
    chk("t2_pop_data", pop_data, 32'hA5A50001);
    chk("t2_count", count, 1);
    pop = 1; tick(); pop = 0; #1;
    chk("t2_drained", empty, 1);

    // Fill with 1..34, pop idle
    k = 1; guard = 0; push = 1;
    while (k <= 33 && guard < 200) begin
      push_data = k; #1; acc = push_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    chk("t3_count", count, 33);
    chk("t3_full", full, 1);
    chk("t3_head", pop_data, 1);
    chk("t3_head_valid", pop_valid, 1);
    push_data = 34;
    repeat (3) begin
      #1; chk("t3_no_accept", push_ready, 0);
      tick();
    end
    chk("t3_count_hold", count, 33);

    // Contention: push and pop held high, grants must alternate
    pop = 1; k = 34; prev = 0;
    for (int i = 0; i < 14; i++) begin
      push_data = k; #1; acc = push_ready;
      if (i >= 4) begin
        chk("t4_ena", ram_ena, 1);
        chk("t4_alternate", ram_wena, !prev);
      end
      prev = ram_wena;
      tick();
      if (acc) k++;
    end
    push = 0; guard = 0;
    while ((pop_valid || count != 0) && guard < 100) begin tick(); guard++; end
    pop = 0; #1;
    chk("t4_drained", empty, 1);

    // Streaming 0..99 with random gaps, across several pointer wraps
    rst_n = 0; tick(); rst_n = 1;
    k = 0; guard = 0;
    while (popped.size() < 100 && guard < 4000) begin
      push = (k < 100) && ($urandom_range(0, 3) != 0);
      push_data = k;
      pop = $urandom_range(0, 1);
      #1; acc = push && push_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    push = 0; pop = 0;
    chk("t5_popped_count", popped.size(), 100);
    for (int i = 0; i < popped.size() && i < 100; i++)
      chk("t5_order", popped[i], i);
    chk("t5_wraps_ge3", wraps >= 3, 1);

    // Reset mid-operation at count=10
    k = 0; guard = 0; push = 1;
    while (k < 10 && guard < 100) begin
      push_data = 32'h100 + k; #1; acc = push_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    push = 0; #1;
    chk("t6_count10", count, 10);
    rst_n = 0; tick(); rst_n = 1;
    push = 1; push_data = 32'h00001234; #1;
    chk("t6_accept", push_ready, 1);
    tick();
    push = 0; tick();
    chk("t6_count", count, 1);
    chk("t6_valid", pop_valid, 1);
    chk("t6_first", pop_data, 32'h00001234);
    pop = 1; tick(); pop = 0; #1;
    chk("t6_empty", empty, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
